yurut_denetleyici: RTL and testbench

YURUT_DENETLEYICI -- requirements
Module: yurut_denetleyici

---
 rtl/yurut_denetleyici_pkg.sv | 20 ++
 rtl/yurut_denetleyici.sv | 124 ++++++++++++
 tb/tb_yurut_denetleyici.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/yurut_denetleyici_pkg.sv
// Shared unit codes and helpers for the execute-stage controller.
// Unit codes select the write-back source downstream.
package yurut_denetleyici_pkg;

    localparam logic [2:0] BIRIM_AMB       = 3'd0;
    localparam logic [2:0] BIRIM_CARPMA    = 3'd1;
    localparam logic [2:0] BIRIM_BOLME     = 3'd2;
    localparam logic [2:0] BIRIM_YAPAYZEKA = 3'd3;
    localparam logic [2:0] BIRIM_BELLEK    = 3'd4;
    localparam logic [2:0] BIRIM_DALLANMA  = 3'd5;
    localparam logic [2:0] BIRIM_CSR       = 3'd6;
    localparam logic [2:0] BIRIM_SISTEM    = 3'd7;

    function automatic logic cok_cevrimli(input logic [2:0] b);
        return (b == BIRIM_CARPMA) ||
               (b == BIRIM_BOLME) ||
               (b == BIRIM_YAPAYZEKA);
    endfunction

endpackage

// File: rtl/yurut_denetleyici.sv
// Execute-stage controller: launches multi-cycle units, stalls the
// pipeline while they run, and retires one result per instruction.
module yurut_denetleyici
    import yurut_denetleyici_pkg::*;
#(
    parameter int CARPMA_GECIKME = 2,
    parameter int ZAMAN_ASIMI    = 64
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cyo_gecerli_i,
    input  logic [2:0] cyo_birim_i,
    input  logic       cyo_bosalt_i,
    input  logic       bol_bitti_i,
    input  logic       yzh_bitti_i,
    output logic       carp_basla_o,
    output logic       bol_basla_o,
    output logic       yzh_basla_o,
    output logic       birim_iptal_o,
    output logic       ddb_dur_o,
    output logic       gy_gecerli_o,
    output logic [2:0] gy_birim_o,
    output logic       hata_o
);

    typedef enum logic [1:0] {
        BOSTA,
        CALISIYOR,
        TAMAM
    } durum_t;

    localparam logic [8:0] GEC_SON   = 9'(CARPMA_GECIKME);
    localparam logic [8:0] ASIM_SON  = 9'(ZAMAN_ASIMI);
    localparam logic [7:0] SAYAC_MAX = 8'(ZAMAN_ASIMI);

    durum_t     durum;
    logic [7:0] sayac;
    logic [2:0] birim_q;

    logic       kabul;
    logic       tek_cevrim;
    logic       calis;
    logic       bitti;
    logic       asim;
    logic [8:0] sayac_art;

    assign sayac_art = {1'b0, sayac} + 9'd1;

    always_comb begin
        bitti = 1'b0;
        unique case (birim_q)
            BIRIM_CARPMA:    bitti = (sayac_art == GEC_SON);
            BIRIM_BOLME:     bitti = bol_bitti_i;
            BIRIM_YAPAYZEKA: bitti = yzh_bitti_i;
            default:         bitti = 1'b0;
        endcase
    end

    // Everything below is gated by rst_ni so reset silences outputs at once.
    always_comb begin
        kabul = rst_ni && (durum == BOSTA) && cyo_gecerli_i &&
                !cyo_bosalt_i && cok_cevrimli(cyo_birim_i);
        tek_cevrim = rst_ni && (durum == BOSTA) && cyo_gecerli_i &&
                     !cyo_bosalt_i && !cok_cevrimli(cyo_birim_i);
        calis = rst_ni && (durum == CALISIYOR);
        asim  = (sayac_art == ASIM_SON);
    end

    always_comb begin
        carp_basla_o  = kabul && (cyo_birim_i == BIRIM_CARPMA);
        bol_basla_o   = kabul && (cyo_birim_i == BIRIM_BOLME);
        yzh_basla_o   = kabul && (cyo_birim_i == BIRIM_YAPAYZEKA);
        ddb_dur_o     = kabul || calis;
        // Flush beats done; done beats timeout.
        birim_iptal_o = calis && (cyo_bosalt_i || (!bitti && asim));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            durum        <= BOSTA;
            sayac        <= 8'd0;
            birim_q      <= 3'd0;
            gy_gecerli_o <= 1'b0;
            gy_birim_o   <= 3'd0;
            hata_o       <= 1'b0;
        end else begin
            gy_gecerli_o <= 1'b0;
            unique case (durum)
                BOSTA: begin
                    if (kabul) begin
                        birim_q <= cyo_birim_i;
                        sayac   <= 8'd0;
                        durum   <= CALISIYOR;
                    end else if (tek_cevrim) begin
                        gy_gecerli_o <= 1'b1;
                        gy_birim_o   <= cyo_birim_i;
                    end
                end
                CALISIYOR: begin
                    if (sayac != SAYAC_MAX) begin
                        sayac <= sayac + 8'd1;
                    end
                    if (cyo_bosalt_i) begin
                        durum <= BOSTA;
                    end else if (bitti) begin
                        durum <= TAMAM;
                    end else if (asim) begin
                        hata_o <= 1'b1;
                        durum  <= BOSTA;
                    end
                end
                TAMAM: begin
                    gy_gecerli_o <= 1'b1;
                    gy_birim_o   <= birim_q;
                    durum        <= BOSTA;
                end
                default: begin
                    durum <= BOSTA;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_yurut_denetleyici.sv
// Directed timeline checks plus randomized traffic against an
// operation-level model of the execute controller.
module tb_yurut_denetleyici;
    import yurut_denetleyici_pkg::*;

    localparam int GEC = 2;
    localparam int ZA  = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       gec = 1'b0;
    logic [2:0] birim = 3'd0;
    logic       bos = 1'b0;
    logic       bb = 1'b0;
    logic       yb = 1'b0;

    logic       carp_basla, bol_basla, yzh_basla;
    logic       iptal, dur, gy_v, hata;
    logic [2:0] gy_u;

    always #5 clk = ~clk;

    yurut_denetleyici #(
        .CARPMA_GECIKME(GEC),
        .ZAMAN_ASIMI   (ZA)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cyo_gecerli_i(gec),
        .cyo_birim_i  (birim),
        .cyo_bosalt_i (bos),
        .bol_bitti_i  (bb),
        .yzh_bitti_i  (yb),
        .carp_basla_o (carp_basla),
        .bol_basla_o  (bol_basla),
        .yzh_basla_o  (yzh_basla),
        .birim_iptal_o(iptal),
        .ddb_dur_o    (dur),
        .gy_gecerli_o (gy_v),
        .gy_birim_o   (gy_u),
        .hata_o       (hata)
    );

    // Operation-level model: one op may be in flight, and a finished op
    // spends one retire cycle before its result appears.
    bit         m_busy, m_ret, m_hata, m_gyv;
    logic [2:0] m_unit, m_gyu;
    int         m_age;

    bit e_carp, e_bol, e_yzh, e_iptal, e_dur;
    bit e_fin, e_tmo, e_acc, e_tek;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    function automatic bit is_multi(input logic [2:0] b);
        return b == BIRIM_CARPMA || b == BIRIM_BOLME || b == BIRIM_YAPAYZEKA;
    endfunction

    task automatic cmp(input string nm, input logic [2:0] act,
                       input logic [2:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic lit(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL lit_%s: got %0d, want %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input bit r, input bit g, input logic [2:0] b,
                          input bit f, input bit d1, input bit d2);
        rst_n = r; gec = g; birim = b; bos = f; bb = d1; yb = d2;
        e_carp = 0; e_bol = 0; e_yzh = 0; e_iptal = 0; e_dur = 0;
        e_fin = 0; e_tmo = 0; e_acc = 0; e_tek = 0;
        if (r) begin
            if (m_busy) begin
                if (m_unit == BIRIM_CARPMA) e_fin = (m_age + 1 == GEC);
                else if (m_unit == BIRIM_BOLME) e_fin = d1;
                else e_fin = d2;
                e_tmo   = (m_age + 1 == ZA);
                e_dur   = 1;
                e_iptal = f || (!e_fin && e_tmo);
            end else if (!m_ret && g && !f) begin
                if (is_multi(b)) begin
                    e_acc  = 1;
                    e_dur  = 1;
                    e_carp = (b == BIRIM_CARPMA);
                    e_bol  = (b == BIRIM_BOLME);
                    e_yzh  = (b == BIRIM_YAPAYZEKA);
                end else begin
                    e_tek = 1;
                end
            end
        end
        #3;
    endtask

    task automatic tick();
        bit nr, nb;
        @(posedge clk);
        if (!rst_n) begin
            m_busy = 0; m_ret = 0; m_hata = 0; m_gyv = 0;
            m_unit = 0; m_gyu = 0; m_age = 0;
        end else begin
            m_gyv = m_ret || e_tek;
            if (m_ret) m_gyu = m_unit;
            else if (e_tek) m_gyu = birim;
            if (m_busy && !bos && !e_fin && e_tmo) m_hata = 1;
            nr = m_busy && !bos && e_fin;
            nb = (m_busy && !bos && !e_fin && !e_tmo) || e_acc;
            if (e_acc) begin
                m_unit = birim;
                m_age  = 0;
            end else if (m_busy) begin
                m_age++;
            end
            m_ret  = nr;
            m_busy = nb;
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            set_in(1, 0, BIRIM_AMB, 0, 0, 0);
            tick();
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            cmp("carp_basla", {2'b0, carp_basla}, {2'b0, e_carp});
            cmp("bol_basla", {2'b0, bol_basla}, {2'b0, e_bol});
            cmp("yzh_basla", {2'b0, yzh_basla}, {2'b0, e_yzh});
            cmp("birim_iptal", {2'b0, iptal}, {2'b0, e_iptal});
            cmp("ddb_dur", {2'b0, dur}, {2'b0, e_dur});
            cmp("gy_gecerli", {2'b0, gy_v}, {2'b0, m_gyv});
            cmp("gy_birim", gy_u, m_gyu);
            cmp("hata", {2'b0, hata}, {2'b0, m_hata});
        end
    end

    initial begin
        int pulses;
        set_in(0, 0, BIRIM_AMB, 0, 0, 0);
        tick();
        chk_en = 1'b1;
        set_in(0, 1, BIRIM_CARPMA, 0, 0, 0);
        lit("rst_dur", {7'b0, dur}, 8'd0);
        lit("rst_basla", {7'b0, carp_basla}, 8'd0);
        tick();
        set_in(1, 0, BIRIM_AMB, 0, 0, 0);
        lit("rst_gy", {7'b0, gy_v}, 8'd0);
        lit("rst_hata", {7'b0, hata}, 8'd0);
        tick();

        // Single-cycle AMB op
        set_in(1, 1, BIRIM_AMB, 0, 0, 0);
        lit("amb_dur", {7'b0, dur}, 8'd0);
        tick();
        set_in(1, 0, BIRIM_AMB, 0, 0, 0);
        lit("amb_gy", {7'b0, gy_v}, 8'd1);
        lit("amb_birim", {5'b0, gy_u}, {5'b0, BIRIM_AMB});
        lit("amb_dur1", {7'b0, dur}, 8'd0);
        tick();

        // CARPMA: stall cycles 0-2, retire cycle 3, result cycle 4
        set_in(1, 1, BIRIM_CARPMA, 0, 0, 0);
        lit("mul_basla", {7'b0, carp_basla}, 8'd1);
        lit("mul_dur0", {7'b0, dur}, 8'd1);
        tick();
        set_in(1, 0, BIRIM_AMB, 0, 0, 0);
        lit("mul_dur1", {7'b0, dur}, 8'd1);
        tick();
        set_in(1, 0, BIRIM_AMB, 0, 0, 0);
        lit("mul_dur2", {7'b0, dur}, 8'd1);
        tick();
        set_in(1, 1, BIRIM_BELLEK, 0, 0, 0);
        lit("mul_dur3", {7'b0, dur}, 8'd0);
        lit("mul_gy3", {7'b0, gy_v}, 8'd0);
        tick();
        set_in(1, 0, BIRIM_AMB, 0, 0, 0);
        lit("mul_gy4", {7'b0, gy_v}, 8'd1);
        lit("mul_birim4", {5'b0, gy_u}, {5'b0, BIRIM_CARPMA});
        tick();
        set_in(1, 0, BIRIM_AMB, 0, 0, 0);
        lit("mul_gy5", {7'b0, gy_v}, 8'd0);
        tick();

        // BOLME finishing at cycle 10
        pulses = 0;
        set_in(1, 1, BIRIM_BOLME, 0, 0, 0);
        lit("div_basla", {7'b0, bol_basla}, 8'd1);
        tick();
        for (int c = 1; c <= 15; c++) begin
            set_in(1, 0, BIRIM_AMB, 0, c == 10, 0);
            if (c == 11) lit("div_dur11", {7'b0, dur}, 8'd0);
            if (c == 12) lit("div_gy12", {7'b0, gy_v}, 8'd1);
            pulses += int'(gy_v);
            tick();
        end
        lit("div_pulses", 8'(pulses), 8'd1);

        // YAPAYZEKA never done: timeout at cycle 64
        pulses = 0;
        set_in(1, 1, BIRIM_YAPAYZEKA, 0, 0, 0);
        tick();
        for (int c = 1; c <= 63; c++) begin
            set_in(1, 0, BIRIM_AMB, 0, 0, 0);
            pulses += int'(gy_v);
            tick();
        end
        set_in(1, 0, BIRIM_AMB, 0, 0, 0);
        lit("tmo_iptal", {7'b0, iptal}, 8'd1);
        lit("tmo_hata64", {7'b0, hata}, 8'd0);
        tick();
        set_in(1, 1, BIRIM_AMB, 0, 0, 0);
        lit("tmo_hata65", {7'b0, hata}, 8'd1);
        pulses += int'(gy_v);
        lit("tmo_nogy", 8'(pulses), 8'd0);
        tick();
        set_in(1, 0, BIRIM_AMB, 0, 0, 0);
        lit("tmo_amb_gy", {7'b0, gy_v}, 8'd1);
        lit("tmo_sticky", {7'b0, hata}, 8'd1);
        tick();

        // BOLME with flush and done together at cycle 5
        set_in(1, 1, BIRIM_BOLME, 0, 0, 0);
        tick();
        idle(4);
        set_in(1, 0, BIRIM_AMB, 1, 1, 0);
        lit("fl_iptal", {7'b0, iptal}, 8'd1);
        tick();
        pulses = 0;
        for (int c = 6; c <= 8; c++) begin
            set_in(1, 0, BIRIM_AMB, 0, 0, 0);
            if (c == 6) lit("fl_dur", {7'b0, dur}, 8'd0);
            pulses += int'(gy_v);
            tick();
        end
        lit("fl_nogy", 8'(pulses), 8'd0);

        // Reset at cycle 3 of a CARPMA op
        set_in(1, 1, BIRIM_CARPMA, 0, 0, 0);
        tick();
        idle(2);
        set_in(0, 1, BIRIM_YAPAYZEKA, 1, 1, 1);
        lit("mr_dur", {7'b0, dur}, 8'd0);
        lit("mr_iptal", {7'b0, iptal}, 8'd0);
        lit("mr_basla", {7'b0, yzh_basla}, 8'd0);
        tick();
        set_in(1, 1, BIRIM_CARPMA, 0, 0, 0);
        lit("mr_gy", {7'b0, gy_v}, 8'd0);
        lit("mr_hata", {7'b0, hata}, 8'd0);
        lit("mr_basla2", {7'b0, carp_basla}, 8'd1);
        tick();
        idle(4);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 199) != 0,
                   $urandom_range(0, 3) != 0,
                   3'($urandom_range(0, 7)),
                   $urandom_range(0, 15) == 0,
                   $urandom_range(0, 19) == 0,
                   $urandom_range(0, 19) == 0);
            tick();
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
